// File: rtl/dcache_stall_ctrl.sv
// Direct-mapped write-back/write-allocate D-cache controller; hits are zero-latency, misses stall via stall_o until DONE.
// Optional hit/miss counters under `DCACHE_STATS_EN; memory side is request-held-until-ack (mem_ack_i ignored in IDLE/DONE).
module dcache_stall_ctrl #(
    parameter int IDX_BITS = 4
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         req_i,
    input  logic         we_i,
    input  logic [31:0]  addr_i,
    input  logic [31:0]  wdata_i,
    output logic [31:0]  rdata_o,
    output logic         stall_o,
    output logic         mem_req_o,
    output logic         mem_we_o,
    output logic [31:0]  mem_addr_o,
    output logic [255:0] mem_wdata_o,
    input  logic [255:0] mem_rdata_i,
    input  logic         mem_ack_i,
    output logic [31:0]  hit_cnt_o,
    output logic [31:0]  miss_cnt_o
);
    localparam int TAG_BITS = 32 - 5 - IDX_BITS;
    localparam int SETS     = 1 << IDX_BITS;

    typedef enum logic [1:0] {IDLE, WBACK, REFILL, DONE} state_t;
    state_t state, state_nxt;

    logic [255:0]        data_mem [SETS];
    logic [TAG_BITS-1:0] tag_mem  [SETS];
    logic [SETS-1:0]     valid;
    logic [SETS-1:0]     dirty;

    logic [2:0]          word;
    logic [IDX_BITS-1:0] idx;
    logic [TAG_BITS-1:0] tag;
    logic [255:0]        line;
    logic [31:0]         line_word;
    logic                hit;
    logic                wr_word;
    logic                fill;
    logic                hit_evt;
    logic                miss_evt;
    logic                unused_bits;

    assign word        = addr_i[4:2];
    assign idx         = addr_i[4+IDX_BITS:5];
    assign tag         = addr_i[31:5+IDX_BITS];
    assign line        = data_mem[idx];
    assign line_word   = line[{word, 5'b0} +: 32];
    assign hit         = valid[idx] && (tag_mem[idx] == tag);
    assign unused_bits = ^addr_i[1:0];

    always_ff @(posedge clk_i) begin
        if (rst_i) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt   = state;
        stall_o     = 1'b0;
        mem_req_o   = 1'b0;
        mem_we_o    = 1'b0;
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        rdata_o     = '0;
        wr_word     = 1'b0;
        fill        = 1'b0;
        hit_evt     = 1'b0;
        miss_evt    = 1'b0;
        case (state)
            IDLE: begin
                if (req_i) begin
                    if (hit) begin
                        hit_evt = 1'b1;
                        if (we_i) wr_word = 1'b1;
                        else      rdata_o = line_word;
                    end else begin
                        stall_o   = 1'b1;
                        miss_evt  = 1'b1;
                        state_nxt = (valid[idx] && dirty[idx]) ? WBACK : REFILL;
                    end
                end
            end
            WBACK: begin
                stall_o     = 1'b1;
                mem_req_o   = 1'b1;
                mem_we_o    = 1'b1;
                mem_addr_o  = {tag_mem[idx], idx, 5'b0};
                mem_wdata_o = line;
                if (mem_ack_i) state_nxt = REFILL;
            end
            REFILL: begin
                stall_o    = 1'b1;
                mem_req_o  = 1'b1;
                mem_addr_o = {tag, idx, 5'b0};
                if (mem_ack_i) begin
                    fill      = 1'b1;
                    state_nxt = DONE;
                end
            end
            DONE: begin
                // The line was just refilled, so the held access now completes as a hit.
                state_nxt = IDLE;
                if (req_i) begin
                    if (we_i) wr_word = 1'b1;
                    else      rdata_o = line_word;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid <= '0;
            dirty <= '0;
        end else begin
            if (fill) begin
                valid[idx] <= 1'b1;
                dirty[idx] <= 1'b0;
            end
            if (wr_word) dirty[idx] <= 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            if (fill) begin
                data_mem[idx] <= mem_rdata_i;
                tag_mem[idx]  <= tag;
            end
            if (wr_word) data_mem[idx][{word, 5'b0} +: 32] <= wdata_i;
        end
    end

`ifdef DCACHE_STATS_EN
    logic [31:0] hit_cnt;
    logic [31:0] miss_cnt;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            hit_cnt  <= '0;
            miss_cnt <= '0;
        end else begin
            if (hit_evt)  hit_cnt  <= hit_cnt + 32'd1;
            if (miss_evt) miss_cnt <= miss_cnt + 32'd1;
        end
    end

    assign hit_cnt_o  = hit_cnt;
    assign miss_cnt_o = miss_cnt;
`else
    logic unused_evt;
    assign unused_evt = hit_evt ^ miss_evt;
    assign hit_cnt_o  = '0;
    assign miss_cnt_o = '0;
`endif

endmodule

// File: tb/tb_dcache_stall_ctrl.sv
// Bench for dcache_stall_ctrl: directed cases plus random traffic against a transparent-cache memory model.
module tb_dcache_stall_ctrl;
    logic         clk;
    logic         rst;
    logic         req;
    logic         we;
    logic [31:0]  addr;
    logic [31:0]  wdata;
    logic [31:0]  rdata;
    logic         stall;
    logic         mem_req;
    logic         mem_we;
    logic [31:0]  mem_addr;
    logic [255:0] mem_wdata;
    logic [255:0] mem_rdata;
    logic         mem_ack;
    logic [31:0]  hit_cnt;
    logic [31:0]  miss_cnt;

    dcache_stall_ctrl dut (
        .clk_i(clk), .rst_i(rst), .req_i(req), .we_i(we), .addr_i(addr),
        .wdata_i(wdata), .rdata_o(rdata), .stall_o(stall), .mem_req_o(mem_req),
        .mem_we_o(mem_we), .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata),
        .mem_rdata_i(mem_rdata), .mem_ack_i(mem_ack), .hit_cnt_o(hit_cnt),
        .miss_cnt_o(miss_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int nchk = 0;
    int nerr = 0;

    // img is what the CPU must observe; mm is what main memory holds.
    logic [31:0] img [logic [29:0]];
    logic [31:0] mm  [logic [29:0]];
    bit          rvld   [16];
    bit          rdirty [16];
    logic [31:0] rline  [16];
    int          nhit;
    int          nmiss;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] exp_cnt(input int n);
`ifdef DCACHE_STATS_EN
        return n;
`else
        return (n == -1) ? 32'd1 : 32'd0;
`endif
    endfunction

    task automatic seed(input logic [31:0] la);
        for (int i = 0; i < 8; i++) begin
            logic [29:0] k;
            k = la[31:2] + 30'(i);
            if (!mm.exists(k)) begin
                mm[k]  = $urandom;
                img[k] = mm[k];
            end
        end
    endtask

    function automatic logic [255:0] line_of(input logic [31:0] la, input bit cpu);
        logic [255:0] l;
        for (int i = 0; i < 8; i++)
            l[i*32 +: 32] = cpu ? img[la[31:2] + 30'(i)] : mm[la[31:2] + 30'(i)];
        return l;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 16; i++) begin
            rvld[i] = 0;
            rdirty[i] = 0;
            rline[i] = '0;
        end
        nhit = 0;
        nmiss = 0;
        img = mm;
    endtask

    task automatic complete(input logic w, input logic [31:0] a, input logic [31:0] d);
        if (w) begin
            img[a[31:2]] = d;
            rdirty[a[8:5]] = 1;
        end else begin
            chk("rdata", rdata, img[a[31:2]]);
        end
    endtask

    task automatic access(input logic w, input logic [31:0] a, input logic [31:0] d, input int lat);
        int          s;
        logic [31:0] la;
        bit          h;
        bit          wb;
        s  = int'(a[8:5]);
        la = {a[31:5], 5'b0};
        seed(la);
        h  = rvld[s] && (rline[s] == la);
        wb = !h && rvld[s] && rdirty[s];
        @(negedge clk);
        req = 1'b1; we = w; addr = a; wdata = d; mem_ack = 1'b0; mem_rdata = '0;
        #1;
        chk("hit_cnt", hit_cnt, exp_cnt(nhit));
        chk("miss_cnt", miss_cnt, exp_cnt(nmiss));
        chk("stall_detect", stall, !h);
        if (h) begin
            chk("hit_mem_req", mem_req, 1'b0);
            complete(w, a, d);
            nhit++;
            @(posedge clk);
            return;
        end
        nmiss++;
        @(posedge clk);
        if (wb) begin
            for (int c = 1; c <= lat; c++) begin
                @(negedge clk);
                mem_ack = (c == lat);
                #1;
                chk("wb_stall", stall, 1'b1);
                chk("wb_req", mem_req, 1'b1);
                chk("wb_we", mem_we, 1'b1);
                chk("wb_addr", mem_addr, rline[s]);
                chk("wb_data", mem_wdata, line_of(rline[s], 1));
                @(posedge clk);
            end
            for (int i = 0; i < 8; i++)
                mm[rline[s][31:2] + 30'(i)] = img[rline[s][31:2] + 30'(i)];
        end
        for (int c = 1; c <= lat; c++) begin
            @(negedge clk);
            mem_ack = (c == lat);
            mem_rdata = line_of(la, 0);
            #1;
            chk("rf_stall", stall, 1'b1);
            chk("rf_req", mem_req, 1'b1);
            chk("rf_we", mem_we, 1'b0);
            chk("rf_addr", mem_addr, la);
            @(posedge clk);
        end
        @(negedge clk);
        mem_ack = 1'b0;
        mem_rdata = '0;
        #1;
        chk("done_stall", stall, 1'b0);
        chk("done_req", mem_req, 1'b0);
        rvld[s] = 1;
        rline[s] = la;
        rdirty[s] = 0;
        complete(w, a, d);
        @(posedge clk);
    endtask

    task automatic idle_cycle(input logic stale_ack);
        @(negedge clk);
        req = 1'b0;
        mem_ack = stale_ack;
        mem_rdata = {8{32'hBAD0_BAD0}};
        #1;
        chk("idle_stall", stall, 1'b0);
        chk("idle_req", mem_req, 1'b0);
        @(posedge clk);
        @(negedge clk);
        mem_ack = 1'b0;
    endtask

    initial begin
        rst = 1'b1; req = 1'b0; we = 1'b0; addr = '0; wdata = '0;
        mem_ack = 1'b0; mem_rdata = '0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        chk("rst_stall", stall, 1'b0);
        chk("rst_mem_req", mem_req, 1'b0);
        chk("rst_mem_we", mem_we, 1'b0);
        chk("rst_mem_addr", mem_addr, 32'h0);
        chk("rst_mem_wdata", mem_wdata, 256'h0);
        chk("rst_rdata", rdata, 32'h0);
        chk("rst_hit_cnt", hit_cnt, 32'h0);
        chk("rst_miss_cnt", miss_cnt, 32'h0);
        rst = 1'b0;
        idle_cycle(1'b1);

        // Cases 1-2: clean miss with word0 seeded, then a hit on word1.
        mm[30'h40] = 32'hDEAD_BEEF;
        img[30'h40] = 32'hDEAD_BEEF;
        access(1'b0, 32'h0000_0100, 32'h0, 3);
        access(1'b0, 32'h0000_0104, 32'h0, 3);

        // Case 3: dirty the line, then evict it with a same-index load.
        access(1'b1, 32'h0000_0100, 32'h1234_5678, 2);
        access(1'b0, 32'h0000_2100, 32'h0, 2);

        // Case 4: store miss onto an all-zero line, reload, then evict to prove dirtiness.
        for (int i = 0; i < 8; i++) begin
            mm[30'hC00 + 30'(i)] = '0;
            img[30'hC00 + 30'(i)] = '0;
        end
        access(1'b1, 32'h0000_3008, 32'hCAFE_F00D, 2);
        access(1'b0, 32'h0000_3008, 32'h0, 2);
        access(1'b0, 32'h0000_1008, 32'h0, 1);

        // Case 5: reset during REFILL, late ack must be ignored.
        seed(32'h0000_04A0);
        @(negedge clk);
        req = 1'b1; we = 1'b0; addr = 32'h0000_04A0;
        #1;
        chk("c5_stall", stall, 1'b1);
        @(posedge clk);
        @(negedge clk);
        #1;
        chk("c5_refill_req", mem_req, 1'b1);
        chk("c5_refill_addr", mem_addr, 32'h0000_04A0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        req = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        mem_ack = 1'b1;
        mem_rdata = {8{32'h5A5A_A5A5}};
        #1;
        chk("c5_req_after_rst", mem_req, 1'b0);
        chk("c5_stall_after_rst", stall, 1'b0);
        chk("c5_miss_cnt_rst", miss_cnt, 32'h0);
        @(posedge clk);
        @(negedge clk);
        mem_ack = 1'b0;
        model_reset();
        access(1'b0, 32'h0000_04A0, 32'h0, 2);
        access(1'b0, 32'h0000_04A4, 32'h0, 2);

        // Random traffic over a few sets and tags to mix hits, clean and dirty misses.
        for (int n = 0; n < 80; n++) begin
            logic [31:0] a;
            a = {23'($urandom_range(0, 3)), 4'($urandom_range(0, 3)),
                 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3))};
            access(1'($urandom_range(0, 1)), a, $urandom, int'($urandom_range(1, 4)));
            if ($urandom_range(0, 4) == 0) idle_cycle(1'($urandom_range(0, 1)));
        end

        idle_cycle(1'b0);
        chk("final_hit_cnt", hit_cnt, exp_cnt(nhit));
        chk("final_miss_cnt", miss_cnt, exp_cnt(nmiss));
        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end
endmodule
